// File: rtl/uart_alu_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_alu_frame_ctrl                                              |
// | Purpose : Assembles A/B/opcode frames from UART bytes, runs the ALU and    |
// |           streams the result back LSB byte first.                          |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module uart_alu_frame_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int OP_WIDTH   = 6,
  parameter int TIMEOUT    = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_done,
  input  logic                  tx_done,
  input  logic [DATA_WIDTH-1:0] alu_res,
  output logic [DATA_WIDTH-1:0] a,
  output logic [DATA_WIDTH-1:0] b,
  output logic [OP_WIDTH-1:0]   op,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  timeout_err,
  output logic                  rx_overrun
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);
  localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  // idle_cnt is 0 in the first cycle after a byte, and timeout_err is
  // registered, so the expiry decision is taken two counts early.
  localparam logic [IDLE_W-1:0] IDLE_FIRE = IDLE_W'((TIMEOUT >= 2) ? TIMEOUT - 2 : 0);

  typedef enum logic [2:0] {
    S_RX_A    = 3'd0,
    S_RX_B    = 3'd1,
    S_RX_OP   = 3'd2,
    S_EXEC    = 3'd3,
    S_TX_LOAD = 3'd4,
    S_TX_WAIT = 3'd5
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic [CNT_W-1:0]        byte_cnt;
  logic [CNT_W-1:0]        cnt_inc;
  logic [IDLE_W-1:0]       idle_cnt;
  logic [DATA_WIDTH-1:0]   res_reg;
  logic [7:0]              next_byte;
  logic                    cnt_last;
  logic                    partial;
  logic                    expire;

  assign cnt_last = (byte_cnt == LAST_BYTE);
  assign cnt_inc  = byte_cnt + CNT_W'(1);
  assign partial  = (state == S_RX_B) || (state == S_RX_OP) ||
                    ((state == S_RX_A) && (byte_cnt != '0));
  assign expire   = (TIMEOUT != 0) && partial && !rx_done && (idle_cnt == IDLE_FIRE);
  assign tx_start = (state == S_TX_LOAD);
  assign busy     = (state == S_EXEC) || (state == S_TX_LOAD) || (state == S_TX_WAIT);

  always_comb begin
    next_byte = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (cnt_inc == CNT_W'(i)) next_byte = res_reg[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_RX_A;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_RX_A: begin
        if (expire)                   next_state = S_RX_A;
        else if (rx_done && cnt_last) next_state = S_RX_B;
      end
      S_RX_B: begin
        if (expire)                   next_state = S_RX_A;
        else if (rx_done && cnt_last) next_state = S_RX_OP;
      end
      S_RX_OP: begin
        if (expire)       next_state = S_RX_A;
        else if (rx_done) next_state = S_EXEC;
      end
      S_EXEC:    next_state = S_TX_LOAD;
      S_TX_LOAD: next_state = S_TX_WAIT;
      S_TX_WAIT: begin
        if (tx_done) next_state = cnt_last ? S_RX_A : S_TX_LOAD;
      end
      default:   next_state = S_RX_A;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a           <= '0;
      b           <= '0;
      op          <= '0;
      tx_data     <= 8'h00;
      res_reg     <= '0;
      byte_cnt    <= '0;
      idle_cnt    <= '0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
      rx_overrun  <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
      rx_overrun  <= rx_done && busy;

      if (!partial || rx_done || expire || (TIMEOUT == 0)) idle_cnt <= '0;
      else                                                 idle_cnt <= idle_cnt + IDLE_W'(1);

      if (expire) begin
        a           <= '0;
        b           <= '0;
        op          <= '0;
        byte_cnt    <= '0;
        timeout_err <= 1'b1;
      end else begin
        case (state)
          S_RX_A: begin
            if (rx_done) begin
              for (int i = 0; i < NBYTES; i++) begin
                if (byte_cnt == CNT_W'(i)) a[8*i +: 8] <= rx_data;
              end
              byte_cnt <= cnt_last ? '0 : cnt_inc;
            end
          end
          S_RX_B: begin
            if (rx_done) begin
              for (int i = 0; i < NBYTES; i++) begin
                if (byte_cnt == CNT_W'(i)) b[8*i +: 8] <= rx_data;
              end
              byte_cnt <= cnt_last ? '0 : cnt_inc;
            end
          end
          S_RX_OP: begin
            if (rx_done) op <= rx_data[OP_WIDTH-1:0];
          end
          S_EXEC: begin
            // First result byte comes straight from the ALU so it is valid
            // in the TX_LOAD cycle alongside tx_start.
            res_reg  <= alu_res;
            tx_data  <= alu_res[7:0];
            byte_cnt <= '0;
          end
          S_TX_WAIT: begin
            if (tx_done) begin
              if (cnt_last) begin
                byte_cnt   <= '0;
                frame_done <= 1'b1;
              end else begin
                byte_cnt <= cnt_inc;
                tx_data  <= next_byte;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_alu_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_uart_alu_frame_ctrl                                           |
// | Purpose : Directed self-checking bench for uart_alu_frame_ctrl (16/8 bit). |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_uart_alu_frame_ctrl;

  logic        clk = 1'b0;
  logic        reset;

  logic [7:0]  rx_data16, txd16;
  logic        rx_done16, tx_done16;
  logic [15:0] alu16, a16, b16;
  logic [5:0]  op16;
  logic        txs16, busy16, fd16, to16, ovr16;

  logic [7:0]  rx_data8, txd8;
  logic        rx_done8, tx_done8;
  logic [7:0]  alu8, a8, b8;
  logic [5:0]  op8;
  logic        txs8, busy8, fd8, to8, ovr8;

  int errors = 0;
  int checks = 0;
  int n_start16 = 0, n_ovr16 = 0, n_fd16 = 0, n_start8 = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  assign alu16 = a16 + b16;
  assign alu8  = a8 - b8;

  uart_alu_frame_ctrl #(.DATA_WIDTH(16), .OP_WIDTH(6), .TIMEOUT(50)) u16 (
    .clk(clk), .reset(reset), .rx_data(rx_data16), .rx_done(rx_done16),
    .tx_done(tx_done16), .alu_res(alu16), .a(a16), .b(b16), .op(op16),
    .tx_data(txd16), .tx_start(txs16), .busy(busy16), .frame_done(fd16),
    .timeout_err(to16), .rx_overrun(ovr16)
  );

  uart_alu_frame_ctrl #(.DATA_WIDTH(8), .OP_WIDTH(6), .TIMEOUT(50)) u8i (
    .clk(clk), .reset(reset), .rx_data(rx_data8), .rx_done(rx_done8),
    .tx_done(tx_done8), .alu_res(alu8), .a(a8), .b(b8), .op(op8),
    .tx_data(txd8), .tx_start(txs8), .busy(busy8), .frame_done(fd8),
    .timeout_err(to8), .rx_overrun(ovr8)
  );

  always @(posedge clk) begin
    if (txs16) n_start16++;
    if (ovr16) n_ovr16++;
    if (fd16)  n_fd16++;
    if (txs8)  n_start8++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic send16(input logic [7:0] d);
    rx_data16 = d; rx_done16 = 1'b1;
    tick;
    rx_done16 = 1'b0;
  endtask

  task automatic send8(input logic [7:0] d);
    rx_data8 = d; rx_done8 = 1'b1;
    tick;
    rx_done8 = 1'b0;
  endtask

  task automatic pulse_tx16;
    tx_done16 = 1'b1;
    tick;
    tx_done16 = 1'b0;
  endtask

  // Pushes the expected result bytes, then sends the whole frame.
  task automatic send_frame16(input logic [15:0] av, input logic [15:0] bv, input logic [7:0] opv);
    logic [15:0] r;
    r = av + bv;
    exp_q.push_back(r[7:0]);
    exp_q.push_back(r[15:8]);
    send16(av[7:0]); send16(av[15:8]);
    send16(bv[7:0]); send16(bv[15:8]);
    send16(opv);
  endtask

  task automatic expect_tx16(input string tag);
    logic [7:0] e;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    else                   e = 'x;
    chk({tag, "_start"}, 64'(txs16), 64'd1);
    chk({tag, "_data"}, 64'(txd16), 64'(e));
  endtask

  // Called in the TX_LOAD cycle of byte 0; finishes in the frame_done cycle.
  task automatic finish_tx16(input string tag);
    expect_tx16({tag, "_b0"});
    tick;
    pulse_tx16;
    expect_tx16({tag, "_b1"});
    tick;
    pulse_tx16;
    chk({tag, "_frame_done"}, 64'(fd16), 64'd1);
  endtask

  initial begin
    int cyc;
    int ovr_before, start_before;
    reset = 1'b1;
    rx_data16 = '0; rx_done16 = 1'b0; tx_done16 = 1'b0;
    rx_data8  = '0; rx_done8  = 1'b0; tx_done8  = 1'b0;
    tick; tick;
    chk("reset16", {a16, b16, op16, txd16, txs16, busy16, fd16, to16, ovr16}, 64'd0);
    chk("reset8",  {a8, b8, op8, txd8, txs8, busy8, fd8, to8, ovr8}, 64'd0);
    reset = 1'b0;
    tick;

    // Basic frame: 0x1234 + 0x0010 = 0x1244
    send_frame16(16'h1234, 16'h0010, 8'h20);
    chk("op_n1", 64'(op16), 64'h20);
    chk("busy_exec", 64'(busy16), 64'd1);
    chk("a_basic", 64'(a16), 64'h1234);
    chk("b_basic", 64'(b16), 64'h0010);
    tick;
    expect_tx16("basic_b0");
    tick;
    chk("tx_start_wait", 64'(txs16), 64'd0);
    pulse_tx16;
    expect_tx16("basic_b1");
    tick;
    pulse_tx16;
    chk("basic_frame_done", 64'(fd16), 64'd1);
    chk("basic_idle", 64'(busy16), 64'd0);
    tick;
    chk("frame_done_pulse", 64'(fd16), 64'd0);
    chk("frame_done_count", 64'(n_fd16), 64'd1);

    // Timeout after a single A byte
    send16(8'h34);
    cyc = 1;
    while (!to16 && cyc < 200) begin
      tick;
      cyc++;
    end
    chk("timeout_cycles", 64'(cyc), 64'd50);
    chk("timeout_a_clear", 64'(a16), 64'd0);
    chk("timeout_op_clear", {b16, op16}, 64'd0);
    tick;
    chk("timeout_pulse", 64'(to16), 64'd0);
    send_frame16(16'h0102, 16'h0304, 8'h20);
    tick;
    finish_tx16("after_to");

    // Byte arriving in the expiry cycle is accepted
    tick;
    send16(8'h11);
    repeat (48) tick;
    send16(8'h22);
    chk("rx_wins_no_to", 64'(to16), 64'd0);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h22);
    send16(8'h01); send16(8'h00); send16(8'h20);
    chk("rx_wins_a", 64'(a16), 64'h2211);
    tick;
    finish_tx16("rx_wins");

    // Overrun during TX_WAIT
    tick;
    send_frame16(16'h00FF, 16'h0001, 8'h20);
    tick;
    expect_tx16("ovr_b0");
    tick;
    send16(8'hFF);
    chk("overrun_pulse", 64'(ovr16), 64'd1);
    chk("overrun_ab", {a16, b16}, 64'h00FF_0001);
    tick;
    chk("overrun_once", 64'(ovr16), 64'd0);
    pulse_tx16;
    expect_tx16("ovr_b1");
    tick;
    pulse_tx16;
    chk("ovr_frame_done", 64'(fd16), 64'd1);

    // Asynchronous reset while in TX_WAIT
    tick;
    send_frame16(16'h1111, 16'h2222, 8'h20);
    tick;
    expect_tx16("rst_b0");
    tick;
    #2 reset = 1'b1;
    #1 chk("reset_async", {a16, b16, op16, txd16, txs16, busy16, fd16, to16, ovr16}, 64'd0);
    exp_q.delete();
    tick;
    reset = 1'b0;
    tick;
    send_frame16(16'hABCD, 16'h1111, 8'h20);
    tick;
    finish_tx16("post_rst");

    // Back-to-back: next frame starts in the frame_done cycle
    ovr_before = n_ovr16;
    tick;
    send_frame16(16'h0005, 16'h0007, 8'h20);
    tick;
    finish_tx16("b2b_1");
    send_frame16(16'h8000, 16'h8001, 8'h20);
    chk("b2b_a", 64'(a16), 64'h8000);
    tick;
    finish_tx16("b2b_2");
    chk("b2b_no_overrun", 64'(n_ovr16), 64'(ovr_before));
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    // 8-bit instance: 5 - 3 = 2, one byte out
    start_before = n_start8;
    send8(8'h05); send8(8'h03); send8(8'h22);
    chk("op8", 64'(op8), 64'h22);
    tick;
    chk("tx8_start", 64'(txs8), 64'd1);
    chk("tx8_data", 64'(txd8), 64'h02);
    tick;
    tx_done8 = 1'b1;
    tick;
    tx_done8 = 1'b0;
    chk("fd8", 64'(fd8), 64'd1);
    tick; tick; tick;
    chk("tx8_count", 64'(n_start8 - start_before), 64'd1);
    chk("busy8_idle", 64'(busy8), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
